// File: rtl/lx32_muldiv.sv
// rtl/lx32_muldiv.sv - iterative RV32M multiply/divide unit, one bit per cycle
module lx32_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] hi_q;   // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;   // multiplier bits / dividend shifting into quotient
    logic [WIDTH-1:0] opb_q;  // multiplicand or divisor magnitude
    logic             neg_q;  // negate product or quotient at the end
    logic             neg_r;  // negate remainder at the end

    logic             accept;
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;
    logic [WIDTH-1:0] fast_result;
    logic             last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   it_hi;
    logic [WIDTH-1:0]   it_lo;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   final_res;

    assign start_ready  = (state == S_IDLE) && !rst;
    assign result_valid = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign accept       = start_valid && start_ready;
    assign last_iter    = (cnt == CW'(WIDTH - 1));

    // Request decode: signedness, magnitudes and the no-iteration divide cases
    always_comb begin
        is_div      = md_op[2];
        a_signed    = (md_op == 3'b001) || (md_op == 3'b010) || (md_op == 3'b100) || (md_op == 3'b110);
        b_signed    = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
        a_neg       = a_signed && src_a[WIDTH-1];
        b_neg       = b_signed && src_b[WIDTH-1];
        mag_a       = a_neg ? -src_a : src_a;
        mag_b       = b_neg ? -src_b : src_b;
        div_zero    = is_div && (src_b == '0);
        div_ovf     = is_div && !md_op[0] && (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
        fast        = div_zero || div_ovf;
        // Overflow quotient equals the dividend itself (most negative value)
        if (div_zero) fast_result = md_op[1] ? src_a : '1;
        else          fast_result = md_op[1] ? '0 : src_a;
    end

    // One shift-add or restoring-subtract step, plus sign fix-up of its outcome
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ok    = !div_diff[WIDTH];
        if (op_q[2]) begin
            it_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod_s = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
        quot_s = neg_q ? -it_lo : it_lo;
        rem_s  = neg_r ? -it_hi : it_hi;
        if (op_q[2])               final_res = op_q[1] ? rem_s : quot_s;
        else if (op_q[1:0] == 2'b00) final_res = prod_s[WIDTH-1:0];
        else                       final_res = prod_s[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = fast ? S_DONE : S_CALC;
            S_CALC: if (last_iter) state_nxt = S_DONE;
            S_DONE: if (result_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, hold result in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= md_op;
                        cnt   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        hi_q  <= '0;
                        lo_q  <= is_div ? mag_a : mag_b;
                        opb_q <= is_div ? mag_b : mag_a;
                        if (fast) result <= fast_result;
                    end
                end
                S_CALC: begin
                    hi_q <= it_hi;
                    lo_q <= it_lo;
                    if (last_iter) result <= final_res;
                    else           cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lx32_muldiv.sv
// tb/tb_lx32_muldiv.sv - randomized self-checking bench for lx32_muldiv
module tb_lx32_muldiv;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        busy;

    int total;
    int bad;

    lx32_muldiv #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .md_op        (md_op),
        .src_a        (src_a),
        .src_b        (src_b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RV32M semantics from 64-bit integer arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issue one request from posedge+1; return once result_valid is seen (lat = edges after accept)
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit sr_seen);
        start_valid = 1'b1;
        md_op       = op;
        src_a       = a;
        src_b       = b;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        md_op       = 3'($urandom);
        src_a       = $urandom;
        src_b       = $urandom;
        lat         = 0;
        sr_seen     = 1'b0;
        while (!result_valid && lat < 200) begin
            if (start_ready) sr_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic retire();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL reset_start_ready got=%b exp=0", start_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        rst = 1'b0;
        #1;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL post_reset_start_ready got=%b exp=1", start_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4};
        logic [31:0] as  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
        logic [31:0] bs  [12] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] exp [12] = '{32'h2A, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        int          elat[12] = '{32, 32, 32, 32, 32, 32, 32, 32, 32, 0, 0, 0};
        logic [31:0] res;
        int          lat;
        bit          sr_seen;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, sr_seen);
            total++; if (res !== exp[i]) begin bad++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, res, exp[i]); end
            total++; if (lat != elat[i]) begin bad++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, elat[i]); end
            total++; if (sr_seen !== 1'b0) begin bad++; $display("FAIL directed_start_ready_busy[%0d] got=1 exp=0", i); end
            retire();
            total++; if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
                bad++; $display("FAIL directed_retire[%0d] got=sr%b/rv%b exp=sr1/rv0", i, start_ready, result_valid);
            end
        end
        // REM with the overflow operands
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sr_seen);
        total++; if (res !== 32'd0 || lat != 0) begin bad++; $display("FAIL rem_overflow got=%h/%0d exp=0/0", res, lat); end
        retire();
    endtask

    task automatic test_back_pressure();
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          sr_seen;
        a   = $urandom;
        b   = $urandom;
        exp = ref_md(3'd0, a, b);
        do_op(3'd0, a, b, res, lat, sr_seen);
        total++; if (res !== exp) begin bad++; $display("FAIL bp_result got=%h exp=%h", res, exp); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (result !== exp || result_valid !== 1'b1 || start_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got=%h/rv%b/sr%b exp=%h/rv1/sr0", i, result, result_valid, start_ready, exp);
            end
        end
        retire();
        total++; if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=rv%b/sr%b exp=rv0/sr1", result_valid, start_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int          lat;
        int          stray;
        bit          sr_seen;
        start_valid = 1'b1;
        md_op       = 3'd0;
        src_a       = 32'h1234_5678;
        src_b       = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (result_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid got=rv%b/busy%b/sr%b exp=rv0/busy0/sr1", result_valid, busy, start_ready);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL rst_mid_stray got=%0d exp=0", stray); end
        do_op(3'd0, 32'd3, 32'd3, res, lat, sr_seen);
        total++; if (res !== 32'd9 || lat != 32) begin bad++; $display("FAIL rst_mid_followup got=%h/%0d exp=9/32", res, lat); end
        retire();
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat, elat;
        bit          sr_seen;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            exp  = ref_md(op, a, b);
            elat = ref_lat(op, a, b);
            do_op(op, a, b, res, lat, sr_seen);
            total++; if (res !== exp || lat != elat) begin
                bad++; $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", i, op, a, b, res, lat, exp, elat);
            end
            retire();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat;
        bit          sr_seen;
        result_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op  = 3'($urandom);
            a   = $urandom;
            b   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            exp = ref_md(op, a, b);
            do_op(op, a, b, res, lat, sr_seen);
            total++; if (res !== exp || lat != ref_lat(op, a, b)) begin
                bad++; $display("FAIL b2b[%0d] op=%0d got=%h/%0d exp=%h/%0d", i, op, res, lat, exp, ref_lat(op, a, b));
            end
            @(posedge clk);
            #1;
            total++; if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_ready[%0d] got=sr%b/rv%b exp=sr1/rv0", i, start_ready, result_valid);
            end
        end
        result_ready = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        start_valid  = 1'b0;
        md_op        = 3'd0;
        src_a        = 32'd0;
        src_b        = 32'd0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_pressure();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
